// File: rtl/adc_stream_framer.sv
// -----------------------------------------------------------------------------
// adc_stream_framer
//   Reads FRAME_LEN bytes from a first-word-fall-through ADC sample FIFO and
//   hands them to the UART TX wrapper as one framed packet:
//     SYNC_HI, SYNC_LO, LEN_HI, LEN_LO, payload[FRAME_LEN], CSUM
//   CSUM is the 8-bit (mod 256) sum of the payload bytes only. Every byte is
//   paced by the wrapper's transmitter-ready level. After each byte, TxReady is
//   ignored for HOLDOFF cycles so the wrapper's busy flag has time to rise.
//
// Ports
//   i_clk            system clock, rising edge
//   i_rst_n          asynchronous active-low reset
//   i_frame_start    1-cycle pulse, begin a frame (ignored while busy)
//   i_frame_abort    1-cycle pulse, end the current frame early (no CSUM)
//   i_fifo_dout[7:0] ADC FIFO head byte (FWFT)
//   i_fifo_empty     ADC FIFO empty
//   o_fifo_rd_en     ADC FIFO pop, asserted together with o_tx_valid
//   i_tx_ready       wrapper transmitter idle (level)
//   o_tx_data[7:0]   byte to wrapper, held between sends
//   o_tx_valid       1-cycle start pulse to wrapper
//   o_streaming_mode wrapper streaming-mode select, high for the whole frame
//   o_busy           high whenever the framer is not idle
//   o_frame_done     1-cycle pulse when a frame ends (normal or aborted)
// -----------------------------------------------------------------------------
module adc_stream_framer #(
  parameter int unsigned FRAME_LEN = 1024,
  parameter logic [15:0] SYNC_WORD = 16'hAA55,
  parameter int unsigned HOLDOFF   = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_frame_start,
  input  logic       i_frame_abort,
  input  logic [7:0] i_fifo_dout,
  input  logic       i_fifo_empty,
  output logic       o_fifo_rd_en,
  input  logic       i_tx_ready,
  output logic [7:0] o_tx_data,
  output logic       o_tx_valid,
  output logic       o_streaming_mode,
  output logic       o_busy,
  output logic       o_frame_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC_H, S_SYNC_L, S_LEN_H, S_LEN_L, S_PAYLOAD, S_CSUM, S_DRAIN
  } state_t;

  localparam int          HO_W     = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);
  localparam logic [HO_W-1:0] HO_LOAD = HO_W'(HOLDOFF);
  localparam logic [15:0] LEN_WORD = 16'(FRAME_LEN);
  localparam logic [15:0] LAST_IDX = 16'(FRAME_LEN - 1);

  state_t          r_state;
  logic [HO_W-1:0] r_holdoff;
  logic [15:0]     r_count;
  logic [7:0]      r_csum;

  logic            w_sending_state;
  logic            w_send;
  logic [7:0]      w_byte;
  state_t          w_next;

  // Byte to send and the state that follows a successful send.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would infer a latch.
    w_byte          = 8'h00;
    w_sending_state = 1'b1;
    w_next          = r_state;
    case (r_state)
      S_SYNC_H:  begin w_byte = SYNC_WORD[15:8]; w_next = S_SYNC_L;  end
      S_SYNC_L:  begin w_byte = SYNC_WORD[7:0];  w_next = S_LEN_H;   end
      S_LEN_H:   begin w_byte = LEN_WORD[15:8];  w_next = S_LEN_L;   end
      S_LEN_L:   begin w_byte = LEN_WORD[7:0];   w_next = S_PAYLOAD; end
      S_PAYLOAD: begin
        w_byte = i_fifo_dout;
        w_next = (r_count == LAST_IDX) ? S_CSUM : S_PAYLOAD;
      end
      S_CSUM:    begin w_byte = r_csum;          w_next = S_DRAIN;   end
      default:   w_sending_state = 1'b0;
    endcase
    // A payload byte also needs data in the FIFO; an empty FIFO simply stalls.
    w_send = w_sending_state && i_tx_ready && (r_holdoff == '0) &&
             !((r_state == S_PAYLOAD) && i_fifo_empty);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state          <= S_IDLE;
      r_holdoff        <= '0;
      r_count          <= '0;
      r_csum           <= '0;
      o_fifo_rd_en     <= 1'b0;
      o_tx_data        <= '0;
      o_tx_valid       <= 1'b0;
      o_streaming_mode <= 1'b0;
      o_busy           <= 1'b0;
      o_frame_done     <= 1'b0;
    end else begin
      // NOTE: state uses non-blocking assignments so every register updates
      // from the same pre-edge values regardless of statement order.
      o_tx_valid   <= 1'b0;
      o_fifo_rd_en <= 1'b0;
      o_frame_done <= 1'b0;

      // Holdoff reloads on every send; it is never zero the cycle after a
      // send, so o_tx_valid cannot be high two cycles running.
      if (w_send) r_holdoff <= HO_LOAD;
      else if (r_holdoff != '0) r_holdoff <= r_holdoff - 1'b1;

      if (w_send) begin
        o_tx_valid <= 1'b1;
        o_tx_data  <= w_byte;
      end

      if (w_send && (r_state == S_PAYLOAD)) begin
        o_fifo_rd_en <= 1'b1;
        r_csum       <= r_csum + i_fifo_dout;
        r_count      <= r_count + 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          // Start beats a coincident abort; abort has no meaning while idle.
          if (i_frame_start) begin
            r_state          <= S_SYNC_H;
            o_streaming_mode <= 1'b1;
            o_busy           <= 1'b1;
            r_csum           <= '0;
            r_count          <= '0;
            r_holdoff        <= '0;
          end
        end
        S_DRAIN: begin
          // Holdoff zero plus ready means the wrapper has finished the last
          // byte, so streaming mode can drop without cutting it off.
          if ((r_holdoff == '0) && i_tx_ready) begin
            r_state          <= S_IDLE;
            o_streaming_mode <= 1'b0;
            o_busy           <= 1'b0;
            o_frame_done     <= 1'b1;
          end
        end
        default: begin
          // A byte sent in the abort cycle still goes out (handled above).
          if (i_frame_abort) r_state <= S_DRAIN;
          else if (w_send)   r_state <= w_next;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_stream_framer.sv
// -----------------------------------------------------------------------------
// tb_adc_stream_framer
//   Directed bench for adc_stream_framer (FRAME_LEN=4). A FIFO model and a
//   UART model (fixed busy time after each start pulse) surround the DUT. The
//   expected byte stream of each frame is built from the framing rules and
//   consumed by a per-cycle compare process; literal frames pin the model.
// -----------------------------------------------------------------------------
module tb_adc_stream_framer;

  localparam int FL = 4;
  localparam int HO = 2;

  typedef struct packed {
    logic [7:0] data;
    logic       pop;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_start = 1'b0;
  logic       frame_abort = 1'b0;
  logic [7:0] fifo_dout;
  logic       fifo_empty;
  logic       fifo_rd_en;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       streaming_mode;
  logic       busy;
  logic       frame_done;

  adc_stream_framer #(.FRAME_LEN(FL), .SYNC_WORD(16'hAA55), .HOLDOFF(HO)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_frame_start(frame_start),
    .i_frame_abort(frame_abort), .i_fifo_dout(fifo_dout),
    .i_fifo_empty(fifo_empty), .o_fifo_rd_en(fifo_rd_en),
    .i_tx_ready(tx_ready), .o_tx_data(tx_data), .o_tx_valid(tx_valid),
    .o_streaming_mode(streaming_mode), .o_busy(busy),
    .o_frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         uart_busy = 0;
  int         busy_len = 10;
  int         pop_cnt = 0;
  int         done_cnt = 0;
  int         last_valid = -100;
  logic       chk_en = 1'b0;
  logic [7:0] fifo_q[$];
  exp_t       exp_q[$];
  logic [7:0] cap_q[$];
  int         stamp_q[$];

  assign tx_ready = (uart_busy == 0);

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fifo_sync();
    fifo_empty = (fifo_q.size() == 0);
    fifo_dout  = fifo_empty ? 8'hEE : fifo_q[0];
  endtask

  // Compare process plus FIFO/UART models, all away from the DUT's edge.
  always @(negedge clk) begin
    exp_t e;
    if (chk_en) begin
      if (tx_valid) begin
        cap_q.push_back(tx_data);
        stamp_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("tx_extra_byte", {24'd0, tx_data}, 32'h100);
        end else begin
          e = exp_q.pop_front();
          check("tx_data", {24'd0, tx_data}, {24'd0, e.data});
          check("fifo_pop", {31'd0, fifo_rd_en}, {31'd0, e.pop});
        end
        check("tx_spacing", {31'd0, (cyc - last_valid) >= (HO + 1)}, 32'd1);
        last_valid = cyc;
      end else begin
        check("pop_without_valid", {31'd0, fifo_rd_en}, 32'd0);
      end
      check("stream_eq_busy", {31'd0, streaming_mode}, {31'd0, busy});
      if (uart_busy > 0) check("stream_in_flight", {31'd0, streaming_mode}, 32'd1);
      if (frame_done) done_cnt++;
    end
    if (tx_valid) uart_busy = busy_len;
    else if (uart_busy > 0) uart_busy--;
    if (fifo_rd_en && fifo_q.size() > 0) begin
      void'(fifo_q.pop_front());
      pop_cnt++;
    end
    fifo_sync();
  end

  task automatic new_test();
    cap_q.delete();
    stamp_q.delete();
    pop_cnt    = 0;
    done_cnt   = 0;
    last_valid = -100;
  endtask

  task automatic load_fifo(input logic [7:0] pl[FL], input int n);
    for (int i = 0; i < n; i++) fifo_q.push_back(pl[i]);
    fifo_sync();
  endtask

  // Expected frame from the framing rules: sync, length, payload, sum mod 256.
  task automatic expect_full(input logic [7:0] pl[FL]);
    int s;
    s = 0;
    exp_q.push_back('{8'hAA, 1'b0});
    exp_q.push_back('{8'h55, 1'b0});
    exp_q.push_back('{8'((FL >> 8) & 255), 1'b0});
    exp_q.push_back('{8'(FL & 255), 1'b0});
    for (int i = 0; i < FL; i++) begin
      exp_q.push_back('{pl[i], 1'b1});
      s = s + int'(pl[i]);
    end
    exp_q.push_back('{8'(s % 256), 1'b0});
  endtask

  task automatic pulse_start(input logic with_abort);
    @(negedge clk);
    frame_start = 1'b1;
    frame_abort = with_abort;
    @(negedge clk);
    frame_start = 1'b0;
    frame_abort = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int d0;
    int i;
    d0 = done_cnt;
    i  = 0;
    while (done_cnt == d0 && i < 3000) begin
      @(posedge clk);
      i++;
    end
    check({name, "_done_timeout"}, {31'd0, done_cnt == d0}, 32'd0);
    check({name, "_exp_drained"}, exp_q.size(), 32'd0);
  endtask

  task automatic wait_cap(input int n, input string name);
    int i;
    i = 0;
    while (cap_q.size() < n && i < 3000) begin
      @(posedge clk);
      i++;
    end
    check({name, "_cap_timeout"}, {31'd0, cap_q.size() < n}, 32'd0);
  endtask

  task automatic check_cap(input string name, input logic [7:0] lit[FL + 5]);
    check({name, "_len"}, cap_q.size(), FL + 5);
    for (int i = 0; i < FL + 5; i++)
      if (i < cap_q.size()) check({name, "_byte"}, {24'd0, cap_q[i]}, {24'd0, lit[i]});
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_rd_en"}, {31'd0, fifo_rd_en}, 32'd0);
    check({name, "_tx_data"}, {24'd0, tx_data}, 32'd0);
    check({name, "_tx_valid"}, {31'd0, tx_valid}, 32'd0);
    check({name, "_stream"}, {31'd0, streaming_mode}, 32'd0);
    check({name, "_busy"}, {31'd0, busy}, 32'd0);
    check({name, "_done"}, {31'd0, frame_done}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    fifo_sync();
    repeat (3) @(posedge clk);
    #1 check_outputs_zero("reset");
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // 1: basic frame, 10-cycle UART busy.
    new_test();
    load_fifo('{8'h01, 8'h02, 8'h03, 8'h04}, 4);
    expect_full('{8'h01, 8'h02, 8'h03, 8'h04});
    pulse_start(1'b0);
    wait_done("t1");
    check_cap("t1", '{8'hAA, 8'h55, 8'h00, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A});
    check("t1_pops", pop_cnt, 4);
    repeat (5) @(posedge clk);
    #1 check("t1_done_once", done_cnt, 1);
    check("t1_idle", {31'd0, busy}, 32'd0);

    // 2: TxReady constantly high, spacing is exactly HOLDOFF+1.
    busy_len = 0;
    new_test();
    load_fifo('{8'hA1, 8'hB2, 8'hC3, 8'hD4}, 4);
    expect_full('{8'hA1, 8'hB2, 8'hC3, 8'hD4});
    pulse_start(1'b0);
    wait_done("t2");
    check_cap("t2", '{8'hAA, 8'h55, 8'h00, 8'h04, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hEA});
    for (int i = 1; i < stamp_q.size(); i++)
      check("t2_gap", stamp_q[i] - stamp_q[i-1], HO + 1);

    // 3: FIFO runs dry after two payload bytes for 50 cycles.
    busy_len = 10;
    new_test();
    load_fifo('{8'h10, 8'h20, 8'h30, 8'h40}, 2);
    expect_full('{8'h10, 8'h20, 8'h30, 8'h40});
    pulse_start(1'b0);
    wait_cap(6, "t3");
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #1;
      check("t3_gap_no_valid", {31'd0, tx_valid}, 32'd0);
      check("t3_gap_stream", {31'd0, streaming_mode}, 32'd1);
    end
    fifo_q.push_back(8'h30);
    fifo_q.push_back(8'h40);
    fifo_sync();
    wait_done("t3");
    check_cap("t3", '{8'hAA, 8'h55, 8'h00, 8'h04, 8'h10, 8'h20, 8'h30, 8'h40, 8'hA0});

    // 4: abort while payload byte 3 is on the wire.
    new_test();
    load_fifo('{8'h05, 8'h06, 8'h07, 8'h08}, 4);
    exp_q.push_back('{8'hAA, 1'b0});
    exp_q.push_back('{8'h55, 1'b0});
    exp_q.push_back('{8'h00, 1'b0});
    exp_q.push_back('{8'h04, 1'b0});
    exp_q.push_back('{8'h05, 1'b1});
    exp_q.push_back('{8'h06, 1'b1});
    exp_q.push_back('{8'h07, 1'b1});
    pulse_start(1'b0);
    wait_cap(7, "t4");
    @(negedge clk);
    frame_abort = 1'b1;
    @(negedge clk);
    frame_abort = 1'b0;
    wait_done("t4");
    repeat (20) @(posedge clk);
    #1 check("t4_bytes", cap_q.size(), 7);
    check("t4_pops", pop_cnt, 3);
    check("t4_done_once", done_cnt, 1);
    fifo_q.delete();
    fifo_sync();

    // 5: reset mid-payload, then a clean frame.
    new_test();
    load_fifo('{8'h01, 8'h02, 8'h03, 8'h04}, 4);
    expect_full('{8'h01, 8'h02, 8'h03, 8'h04});
    pulse_start(1'b0);
    wait_cap(5, "t5");
    @(negedge clk);
    chk_en = 1'b0;
    rst_n  = 1'b0;
    #1 check_outputs_zero("t5_reset");
    exp_q.delete();
    fifo_q.delete();
    uart_busy = 0;
    fifo_sync();
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    new_test();
    load_fifo('{8'h11, 8'h22, 8'h33, 8'h44}, 4);
    expect_full('{8'h11, 8'h22, 8'h33, 8'h44});
    pulse_start(1'b0);
    wait_done("t5");
    check_cap("t5", '{8'hAA, 8'h55, 8'h00, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA});

    // 6: checksum wrap; start+abort in idle starts; start while busy ignored.
    new_test();
    load_fifo('{8'hFF, 8'hFF, 8'hFF, 8'hFF}, 4);
    expect_full('{8'hFF, 8'hFF, 8'hFF, 8'hFF});
    pulse_start(1'b1);
    wait_cap(6, "t6");
    pulse_start(1'b0);
    wait_done("t6");
    check_cap("t6", '{8'hAA, 8'h55, 8'h00, 8'h04, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFC});
    repeat (20) @(posedge clk);
    #1 check("t6_idle", {31'd0, busy}, 32'd0);
    check("t6_done_once", done_cnt, 1);
    check("t6_no_restart", cap_q.size(), FL + 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
